// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32 DIV/DIVU/REM/REMU: one quotient bit per
// clock, fixed WIDTH+1 cycle latency from accepted start to the done pulse.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] sel;
  logic             signed_op;
  logic             dvd_neg;
  logic             dvs_neg;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    result_d  = result_q;
    signed_op = ~op[0];
    dvd_neg   = signed_op & dividend[WIDTH-1];
    dvs_neg   = signed_op & divisor[WIDTH-1];
    // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
    // and the top bit of the trial difference is its sign.
    shifted   = {rem_q, quo_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};
    sel       = op_q[1] ? rem_q : quo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          quo_d   = dvd_neg ? ('0 - dividend) : dividend;
          dvs_d   = dvs_neg ? ('0 - divisor) : divisor;
          qneg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & (|divisor);
          rneg_d  = dvd_neg;
          dz_d    = ~|divisor;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        // With a zero divisor the remainder path already yields the original
        // dividend after sign restore; only the quotient needs forcing.
        if (dz_q && !op_q[1]) begin
          result_d = '1;
        end else if (op_q[1] ? rneg_q : qneg_q) begin
          result_d = '0 - sel;
        end else begin
          result_d = sel;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
